// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// disp_pkg : shared types, glyph codes and 7-segment encoder for disp7seg_driver
// Rev 1.0
// ============================================================================
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SHIFT  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  // Glyphs 0..15 are hex digits; the two above them are non-numeric symbols.
  typedef logic [4:0] glyph_t;

  localparam glyph_t G_BLANK    = 5'd16;
  localparam glyph_t G_MINUS    = 5'd17;
  localparam int     BCD_DIGITS = 5;

  // Active-low cathodes, bit0 = a ... bit6 = g.
  function automatic logic [6:0] seg_encode(input glyph_t g);
    logic [6:0] s;
    case (g)
      5'd0:    s = 7'b1000000;
      5'd1:    s = 7'b1111001;
      5'd2:    s = 7'b0100100;
      5'd3:    s = 7'b0110000;
      5'd4:    s = 7'b0011001;
      5'd5:    s = 7'b0010010;
      5'd6:    s = 7'b0000010;
      5'd7:    s = 7'b1111000;
      5'd8:    s = 7'b0000000;
      5'd9:    s = 7'b0010000;
      5'd10:   s = 7'b0001000;
      5'd11:   s = 7'b0000011;
      5'd12:   s = 7'b1000110;
      5'd13:   s = 7'b0100001;
      5'd14:   s = 7'b0000110;
      5'd15:   s = 7'b0001110;
      5'd17:   s = 7'b0111111;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// bin2bcd_seq : 16-bit binary to 5-digit BCD, one double-dabble step per cycle
// Rev 1.0
// ============================================================================
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [15:0]             bin,
  output logic [4*BCD_DIGITS-1:0] bcd,
  output logic                    done
);

  logic [15:0]             r_bin;
  logic [4*BCD_DIGITS-1:0] r_bcd;
  logic [3:0]              r_cnt;
  logic                    r_run;
  logic [4*BCD_DIGITS-1:0] w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (start) begin
      r_bin <= bin;
      r_bcd <= '0;
      r_cnt <= '0;
      r_run <= 1'b1;
    end else if (r_run) begin
      {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
      r_cnt          <= r_cnt + 4'd1;
      if (r_cnt == 4'd15) r_run <= 1'b0;
    end
  end

  // Asserted during the final iteration; bcd is complete on the next cycle.
  assign done = r_run && (r_cnt == 4'd15);
  assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/disp7seg_driver.sv
`default_nettype none
// ============================================================================
// disp7seg_driver : calculator result to 8-digit multiplexed 7-segment display
// Rev 1.0
// ============================================================================
module disp7seg_driver
  import disp_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int N_DIGITS   = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         value,
  input  logic                signed_mode,
  input  logic                hex_mode,
  input  logic [2:0]          status,
  output logic [6:0]          segments,
  output logic                dp,
  output logic [N_DIGITS-1:0] anodes,
  output logic                busy
);

  localparam int c_presc_max = CLK_HZ / REFRESH_HZ - 1;
  localparam int c_presc_w   = (c_presc_max > 0) ? $clog2(c_presc_max + 1) : 1;
  localparam int c_idx_w     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  state_t                  r_state, w_next;
  logic [15:0]             r_snap_value;
  logic                    r_snap_signed, r_snap_hex, r_snap_valid, r_neg;
  glyph_t                  r_digit [0:5];
  glyph_t                  w_new   [0:5];
  logic                    w_neg, w_changed, w_start, w_done;
  logic [15:0]             w_mag;
  logic [4*BCD_DIGITS-1:0] w_bcd;
  int                      w_msd, w_idx;
  glyph_t                  w_glyph;
  logic [c_presc_w-1:0]    r_presc;
  logic [c_idx_w-1:0]      r_idx;
  logic [N_DIGITS-1:0]     r_anodes;
  logic [6:0]              r_segments;

  assign w_neg     = signed_mode & ~hex_mode & value[15];
  assign w_mag     = w_neg ? (~value + 16'd1) : value;
  assign w_changed = !r_snap_valid ||
                     ({value, signed_mode, hex_mode} != {r_snap_value, r_snap_signed, r_snap_hex});
  assign w_start   = (r_state == LOAD) && !hex_mode;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst_n (reset),
    .start (w_start),
    .bin   (w_mag),
    .bcd   (w_bcd),
    .done  (w_done)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_changed) w_next = LOAD;
      LOAD:    w_next = hex_mode ? COMMIT : SHIFT;
      SHIFT:   if (w_done) w_next = COMMIT;
      default: w_next = IDLE;
    endcase
  end

  // Leading-zero blanking with the minus sign hugging the leftmost shown digit.
  always_comb begin
    w_msd = 0;
    for (int i = 0; i < 6; i++) w_new[i] = G_BLANK;
    if (r_snap_hex) begin
      for (int i = 0; i < 4; i++) w_new[i] = {1'b0, r_snap_value[4*i +: 4]};
    end else begin
      for (int i = 1; i < BCD_DIGITS; i++) begin
        if (w_bcd[4*i +: 4] != 4'd0) w_msd = i;
      end
      for (int i = 0; i < BCD_DIGITS; i++) begin
        if (i <= w_msd) w_new[i] = {1'b0, w_bcd[4*i +: 4]};
      end
      for (int i = 1; i < 6; i++) begin
        if (r_neg && (i == w_msd + 1)) w_new[i] = G_MINUS;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_snap_value  <= '0;
      r_snap_signed <= 1'b0;
      r_snap_hex    <= 1'b0;
      r_snap_valid  <= 1'b0;
      r_neg         <= 1'b0;
      for (int i = 0; i < 6; i++) r_digit[i] <= G_BLANK;
    end else begin
      r_state <= w_next;
      if (r_state == LOAD) begin
        r_snap_value  <= value;
        r_snap_signed <= signed_mode;
        r_snap_hex    <= hex_mode;
        r_neg         <= w_neg;
      end
      if (r_state == COMMIT) begin
        for (int i = 0; i < 6; i++) r_digit[i] <= w_new[i];
        r_snap_valid <= 1'b1;
      end
    end
  end

  // Digit 6 is permanently blank; digit 7 tracks status directly.
  always_comb begin
    w_idx   = int'(r_idx);
    w_glyph = G_BLANK;
    if (w_idx == 7)     w_glyph = {2'b00, status};
    else if (w_idx < 6) w_glyph = r_digit[w_idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc    <= '0;
      r_idx      <= '0;
      r_anodes   <= '1;
      r_segments <= 7'h7F;
    end else begin
      if (r_presc == c_presc_w'(c_presc_max)) begin
        r_presc <= '0;
        r_idx   <= (r_idx == c_idx_w'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      r_anodes   <= ~(N_DIGITS'(1) << r_idx);
      r_segments <= seg_encode(w_glyph);
    end
  end

  assign anodes   = r_anodes;
  assign segments = r_segments;
  assign dp       = 1'b1;
  assign busy     = (r_state != IDLE);

endmodule
`default_nettype wire
